// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-meter front end: edge-select encodings,
// filter state type, idle timeout default and glitch counter ceiling.
package freq_meas_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  localparam int IDLE_US_DEFAULT = 1_000_000;
  localparam logic [7:0] GLITCH_MAX = 8'hFF;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } filt_state_e;

  // 2'b11 deliberately falls into the rising-edge default.
  function automatic logic edge_match(input logic [1:0] sel, input logic prev, input logic cur);
    case (sel)
      EDGE_FALL: return prev & ~cur;
      EDGE_BOTH: return prev ^ cur;
      default:   return ~prev & cur;
    endcase
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Flop chain bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sig_conditioner.sv
// Measured-signal front end: synchroniser, pulse-width glitch filter, edge
// qualifier producing clk_enable, signal-presence timeout and glitch statistics.
module sig_conditioner
  import freq_meas_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int IDLE_US     = IDLE_US_DEFAULT,
  parameter int IDLE_W      = 20
) (
  input  logic              fpga_clk,
  input  logic              reset,
  input  logic              signal_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [1:0]        edge_sel,
  input  logic              tick_1us,
  input  logic              clr_stats,
  output logic              clk_enable,
  output logic              sig_filtered,
  output logic              sig_present,
  output logic [7:0]        glitch_cnt
);

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_US);
  localparam logic [FILT_W-1:0] CNT_MAX  = '1;

  logic              sync_q;
  filt_state_e       state_q;
  logic [FILT_W-1:0] cnt_q;
  logic              filt_q;
  logic              filt_prev_q;
  logic              clk_en_q;
  logic              present_q;
  logic [7:0]        glitch_q;
  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_d;
  logic              bypass;
  logic              glitch_abort;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (fpga_clk),
    .srst (reset),
    .d_i  (signal_in),
    .q_o  (sync_q)
  );

  assign bypass       = (filt_len == '0);
  // In bypass the filter never counts a glitch, even if left mid-PENDING.
  assign glitch_abort = (state_q == PENDING) && (sync_q == filt_q) && !bypass;

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      filt_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      case (state_q)
        STABLE: begin
          if (bypass) begin
            filt_q <= sync_q;
          end else if (sync_q != filt_q) begin
            state_q <= PENDING;
            cnt_q   <= FILT_W'(1);
          end
        end
        PENDING: begin
          if (sync_q == filt_q) begin
            state_q <= STABLE;
          end else if (cnt_q >= filt_len) begin
            filt_q  <= sync_q;
            state_q <= STABLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= STABLE;
      endcase

      if (clr_stats) begin
        glitch_q <= '0;
      end else if (glitch_abort && glitch_q != GLITCH_MAX) begin
        glitch_q <= glitch_q + 8'd1;
      end
    end
  end

  // A qualified edge restarts the timeout even if a tick lands in the same cycle.
  always_comb begin
    idle_d = idle_q;
    if (clk_en_q) begin
      idle_d = '0;
    end else if (tick_1us && idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      filt_prev_q <= 1'b0;
      clk_en_q    <= 1'b0;
      present_q   <= 1'b0;
      idle_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      clk_en_q    <= edge_match(edge_sel, filt_prev_q, filt_q);
      idle_q      <= idle_d;
      if (clk_en_q) begin
        present_q <= 1'b1;
      end else if (idle_d == IDLE_MAX) begin
        present_q <= 1'b0;
      end
    end
  end

  assign clk_enable   = clk_en_q;
  assign sig_filtered = filt_q;
  assign sig_present  = present_q;
  assign glitch_cnt   = glitch_q;

endmodule
